kt_transpose_buffer: RTL and testbench

//  Ping-pong block buffer between the linear-projection output and the Qn*KnT matrix core.
//  - The linear projection writes the K matrix one BLOCK_SIZE x BLOCK_SIZE block per beat, in row-major block order.
//  - This block reads the matrix back as K^T: transposed block order, with each block internally transposed.
//  - Two banks let matrix n+1 be written while matrix n is read.

---
 rtl/kt_transpose_buffer.sv | 176 +++++++++++++++++
 tb/tb_kt_transpose_buffer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/kt_transpose_buffer.sv
// rtl/kt_transpose_buffer.sv - ping-pong K block buffer that reads the matrix back as K^T
// Optional macro KT_BUF_V_MODE_EN adds transpose_en for a per-bank untransposed (V path) read mode.
module kt_transpose_buffer #(
    parameter int WIDTH_OUT  = 16,
    parameter int BLOCK_SIZE = 2,
    parameter int CHUNK_SIZE = 4,
    parameter int ROW_BLOCKS = 4,
    parameter int COL_BLOCKS = 2
) (
    input  logic                            clk,
    input  logic                            rst,
`ifdef KT_BUF_V_MODE_EN
    input  logic                            transpose_en,
`endif
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WIDTH_OUT*CHUNK_SIZE-1:0] in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH_OUT*CHUNK_SIZE-1:0] out_data,
    output logic                            out_last
);

    localparam int DW   = WIDTH_OUT * CHUNK_SIZE;
    localparam int NBLK = ROW_BLOCKS * COL_BLOCKS;
    localparam int RW   = (ROW_BLOCKS > 1) ? $clog2(ROW_BLOCKS) : 1;
    localparam int CW   = (COL_BLOCKS > 1) ? $clog2(COL_BLOCKS) : 1;
    localparam int IW   = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam logic [RW-1:0] R_MAX = RW'(ROW_BLOCKS - 1);
    localparam logic [CW-1:0] C_MAX = CW'(COL_BLOCKS - 1);

    logic [DW-1:0] mem_q [2][NBLK];

    logic [1:0]    full_q, full_d;
    logic          wr_sel_q, wr_sel_d;
    logic          rd_sel_q, rd_sel_d;
    logic [RW-1:0] wr_r_q, wr_r_d;
    logic [CW-1:0] wr_c_q, wr_c_d;
    logic [RW-1:0] rd_r_q, rd_r_d;
    logic [CW-1:0] rd_c_q, rd_c_d;

    logic          wr_fire, rd_fire;
    logic          wr_last, rd_last;
    logic          rd_tr;
    logic [IW-1:0] wr_idx, rd_idx;
    logic [DW-1:0] rd_blk;

    assign in_ready  = !full_q[wr_sel_q];
    assign out_valid = full_q[rd_sel_q];
    assign wr_fire   = in_valid && in_ready;
    assign rd_fire   = out_valid && out_ready;
    assign wr_last   = (wr_r_q == R_MAX) && (wr_c_q == C_MAX);
    assign rd_last   = (rd_r_q == R_MAX) && (rd_c_q == C_MAX);
    assign out_last  = out_valid && rd_last;
    assign wr_idx    = IW'(int'(wr_r_q) * COL_BLOCKS + int'(wr_c_q));
    assign rd_idx    = IW'(int'(rd_r_q) * COL_BLOCKS + int'(rd_c_q));
    assign rd_blk    = mem_q[rd_sel_q][rd_idx];

`ifdef KT_BUF_V_MODE_EN
    logic [1:0] tmode_q, tmode_d;

    assign rd_tr = tmode_q[rd_sel_q];

    // Mode is captured on the first beat of a matrix so it follows the data into its bank.
    always_comb begin
        tmode_d = tmode_q;
        if (wr_fire && (wr_r_q == '0) && (wr_c_q == '0)) begin
            tmode_d[wr_sel_q] = transpose_en;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmode_q <= 2'b11;
        end else begin
            tmode_q <= tmode_d;
        end
    end
`else
    assign rd_tr = 1'b1;
`endif

    // Block storage carries no reset: out_data is masked by out_valid and full_q gates every read.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_sel_q][wr_idx] <= in_data;
        end
    end

    always_comb begin
        full_d   = full_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        wr_r_d   = wr_r_q;
        wr_c_d   = wr_c_q;
        rd_r_d   = rd_r_q;
        rd_c_d   = rd_c_q;

        if (wr_fire) begin
            if (wr_last) begin
                wr_r_d           = '0;
                wr_c_d           = '0;
                full_d[wr_sel_q] = 1'b1;
                wr_sel_d         = ~wr_sel_q;
            end else if (wr_c_q == C_MAX) begin
                wr_c_d = '0;
                wr_r_d = wr_r_q + 1'b1;
            end else begin
                wr_c_d = wr_c_q + 1'b1;
            end
        end

        // Write and read banks always differ, so a simultaneous set and clear both land.
        if (rd_fire) begin
            if (rd_last) begin
                rd_r_d           = '0;
                rd_c_d           = '0;
                full_d[rd_sel_q] = 1'b0;
                rd_sel_d         = ~rd_sel_q;
            end else if (rd_tr) begin
                if (rd_r_q == R_MAX) begin
                    rd_r_d = '0;
                    rd_c_d = rd_c_q + 1'b1;
                end else begin
                    rd_r_d = rd_r_q + 1'b1;
                end
            end else begin
                if (rd_c_q == C_MAX) begin
                    rd_c_d = '0;
                    rd_r_d = rd_r_q + 1'b1;
                end else begin
                    rd_c_d = rd_c_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q   <= '0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            wr_r_q   <= '0;
            wr_c_q   <= '0;
            rd_r_q   <= '0;
            rd_c_q   <= '0;
        end else begin
            full_q   <= full_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            wr_r_q   <= wr_r_d;
            wr_c_q   <= wr_c_d;
            rd_r_q   <= rd_r_d;
            rd_c_q   <= rd_c_d;
        end
    end

    // Element (i,j) of the output block comes from element (j,i) of the stored block.
    always_comb begin
        out_data = '0;
        if (out_valid) begin
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                for (int j = 0; j < BLOCK_SIZE; j++) begin
                    if (rd_tr) begin
                        out_data[(i*BLOCK_SIZE+j)*WIDTH_OUT +: WIDTH_OUT] =
                            rd_blk[(j*BLOCK_SIZE+i)*WIDTH_OUT +: WIDTH_OUT];
                    end else begin
                        out_data[(i*BLOCK_SIZE+j)*WIDTH_OUT +: WIDTH_OUT] =
                            rd_blk[(i*BLOCK_SIZE+j)*WIDTH_OUT +: WIDTH_OUT];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_kt_transpose_buffer.sv
// tb/tb_kt_transpose_buffer.sv - scoreboard bench for kt_transpose_buffer
module tb_kt_transpose_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_last;
`ifdef KT_BUF_V_MODE_EN
    logic        transpose_en;
`endif

    int checks   = 0;
    int failures = 0;

    logic [64:0] exp_q[$];

    int ord_t[8] = '{0, 2, 4, 6, 1, 3, 5, 7};
    int perm_t[4] = '{0, 2, 1, 3};

    kt_transpose_buffer dut (
        .clk         (clk),
        .rst         (rst),
`ifdef KT_BUF_V_MODE_EN
        .transpose_en(transpose_en),
`endif
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [63:0] blk(input int base, input int k);
        logic [63:0] r;
        for (int e = 0; e < 4; e++) r[e*16 +: 16] = 16'(base + 4*k + e);
        return r;
    endfunction

    task automatic push_matrix(input int base, input bit tr);
        logic [63:0] d;
        int k;
        for (int b = 0; b < 8; b++) begin
            k = tr ? ord_t[b] : b;
            for (int e = 0; e < 4; e++) d[e*16 +: 16] = 16'(base + 4*k + (tr ? perm_t[e] : e));
            exp_q.push_back({(b == 7), d});
        end
    endtask

    task automatic write_blocks(input int base, input int first, input int n);
        int t;
        for (int k = first; k < first + n; k++) begin
            in_valid = 1'b1;
            in_data  = blk(base, k);
            t = 0;
            while (!in_ready && t < 200) begin
                @(posedge clk); #1;
                t++;
            end
            if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name, input bit rnd);
        int t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            t++;
        end
        out_ready = 1'b1;
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Monitor: pops and compares accepted beats, checks idle zeros and stall stability.
    logic [63:0] held_d;
    logic        held_l;
    bit          held_v = 1'b0;
    always @(negedge clk) begin
        logic [64:0] e;
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v && out_valid) begin
                check("stall_data_stable", out_data, held_d);
                check("stall_last_stable", 64'(out_last), 64'(held_l));
            end
            if (!out_valid) begin
                check("idle_data_zero", out_data, 64'd0);
                check("idle_last_zero", 64'(out_last), 64'd0);
            end else if (out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", out_data, e[63:0]);
                    check("beat_last", 64'(out_last), 64'(e[64]));
                end
            end
            held_v = out_valid && !out_ready;
            held_d = out_data;
            held_l = out_last;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
`ifdef KT_BUF_V_MODE_EN
        transpose_en = 1'b1;
`endif
        @(posedge clk); @(posedge clk); #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_last", 64'(out_last), 64'd0);
        check("reset_out_data", out_data, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: single matrix, latency and transposed order
        push_matrix(0, 1'b1);
        write_blocks(0, 0, 7);
        check("t1_valid_before_last_write", 64'(out_valid), 64'd0);
        write_blocks(0, 7, 1);
        check("t1_valid_after_last_write", 64'(out_valid), 64'd1);
        check("t1_block0", out_data, 64'h0003_0001_0002_0000);
        check("t1_block0_not_last", 64'(out_last), 64'd0);
        drain("t1_drain", 1'b0);

        // 2: fill both banks, then stream both matrices back to back
        out_ready = 1'b0;
        push_matrix(0, 1'b1);
        push_matrix(64, 1'b1);
        write_blocks(0, 0, 8);
        check("t2_in_ready_one_bank_full", 64'(in_ready), 64'd1);
        write_blocks(64, 0, 8);
        check("t2_in_ready_both_full", 64'(in_ready), 64'd0);
        repeat (3) begin @(posedge clk); #1; end
        check("t2_stalled_block0", out_data, 64'h0003_0001_0002_0000);
        out_ready = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            @(posedge clk); #1;
            if (e == 7) check("t2_in_ready_before_free", 64'(in_ready), 64'd0);
            if (e == 8) check("t2_in_ready_after_free", 64'(in_ready), 64'd1);
            if (e == 8) check("t2_b_no_gap", 64'(out_valid), 64'd1);
        end
        check("t2_drained_in_16", 64'(exp_q.size()), 64'd0);
        check("t2_idle_after", 64'(out_valid), 64'd0);

        // 3: random back-pressure
        out_ready = 1'b0;
        push_matrix(128, 1'b1);
        write_blocks(128, 0, 8);
        drain("t3_drain", 1'b1);

        // 4: reset mid-matrix discards the partial write
        write_blocks(300, 0, 5);
        pulse_reset();
        check("t4_rst_in_ready", 64'(in_ready), 64'd1);
        check("t4_rst_out_valid", 64'(out_valid), 64'd0);
        push_matrix(200, 1'b1);
        write_blocks(200, 0, 8);
        drain("t4_drain", 1'b0);

        // 5: write-last to bank 1 coincides with read-last from bank 0
        pulse_reset();
        push_matrix(400, 1'b1);
        push_matrix(500, 1'b1);
        for (int e = 1; e <= 24; e++) begin
            if (e <= 16) begin
                in_valid = 1'b1;
                in_data  = (e <= 8) ? blk(400, e - 1) : blk(500, e - 9);
            end else begin
                in_valid = 1'b0;
            end
            if (e == 16) check("t5_in_ready_at_write_last", 64'(in_ready), 64'd1);
            @(posedge clk); #1;
            if (e == 8 || e == 16 || e == 23) check("t5_out_valid", 64'(out_valid), 64'd1);
            if (e == 15) check("t5_m1_last", 64'(out_last), 64'd1);
            if (e == 16) check("t5_m2_block0", out_data, 64'h01F7_01F5_01F6_01F4);
            if (e == 24) check("t5_idle", 64'(out_valid), 64'd0);
        end
        check("t5_drained", 64'(exp_q.size()), 64'd0);

`ifdef KT_BUF_V_MODE_EN
        // 6: untransposed V matrix, then a transposed K matrix
        transpose_en = 1'b0;
        push_matrix(600, 1'b0);
        write_blocks(600, 0, 8);
        check("t6_v_block0", out_data, 64'h025B_025A_0259_0258);
        transpose_en = 1'b1;
        push_matrix(0, 1'b1);
        write_blocks(0, 0, 8);
        drain("t6_drain", 1'b0);
`endif

        repeat (2) begin @(posedge clk); #1; end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
